// File: rtl/nios_dbg_ocimem_access.sv
// Debug memory access engine: decodes ocimem take_action strobes from the
// debug-slave wrapper into single-word Avalon-MM reads/writes with a stall timeout.
module nios_dbg_ocimem_access #(
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [ADDR_W-1:0] jdo_addr;
    logic              any_strobe;
    logic              unused_jdo;

    assign jdo_addr       = jdo[ADDR_W+16:17];
    assign any_strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign avm_byteenable = 4'hF;
    assign unused_jdo     = ^{jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            MonDReg       <= '0;
            MonAReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        MonAReg <= jdo_addr;
                        if (jdo[35]) monitor_error <= 1'b0;
                        if (jdo[34]) begin
                            avm_address   <= jdo_addr;
                            avm_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                            tmo_cnt       <= '0;
                            state         <= RD;
                        end
                    end else if (take_action_ocimem_b) begin
                        MonDReg       <= jdo[34:3];
                        avm_writedata <= jdo[34:3];
                        avm_address   <= MonAReg;
                        avm_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        tmo_cnt       <= '0;
                        state         <= WR;
                    end else if (take_no_action_ocimem_a) begin
                        avm_address   <= MonAReg;
                        avm_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                        tmo_cnt       <= '0;
                        state         <= RD;
                    end
                end
                default: begin
                    // Strobes arriving mid-access are dropped but flagged.
                    if (any_strobe) monitor_error <= 1'b1;
                    if (!avm_waitrequest) begin
                        if (state == RD) MonDReg <= avm_readdata;
                        MonAReg       <= MonAReg + ADDR_W'(1);
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
